// File: rtl/pipe_stage_buf_pkg.sv
// Shared types and defaults for the elastic pipeline-stage buffers.
// Stage payload structs live here so each boundary can size DATA_W with $bits().
package pipe_stage_buf_pkg;

    localparam int DEFAULT_DATA_W = 128;
    localparam int DEFAULT_DEPTH  = 2;
    localparam int DEFAULT_CNT_W  = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pred_pc;
        logic [31:0] ctrl;
    } fetch_decode_t;

    localparam fetch_decode_t FD_BUBBLE = '0;

    // A single-entry buffer still needs a legal one-bit pointer type.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter used for the stall-cycle performance counter.
module sat_counter
    import pipe_stage_buf_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready buffer between two pipeline stages, with flush,
// a sticky halt lock-out and a saturating stall-cycle counter.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int                DATA_W = DEFAULT_DATA_W,
    parameter int                DEPTH  = DEFAULT_DEPTH,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int                CNT_W  = DEFAULT_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_halt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_halt,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int             CW   = $clog2(DEPTH) + 1;
    localparam int             PW   = ptr_width(DEPTH);
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    logic [DATA_W:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            halt_lock;
    logic            push;
    logic            pop;
    logic [DATA_W:0] head;

    function automatic logic [PW-1:0] advance(input logic [PW-1:0] ptr);
        return (DEPTH == 1) ? '0 : ptr + 1'b1;
    endfunction

    // in_ready depends on registered state only, so a full buffer cannot
    // accept in the same cycle it is popped.
    assign in_ready  = (count < FULL) && !halt_lock;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign head      = mem[rd_ptr];
    assign out_data  = out_valid ? head[DATA_W-1:0] : BUBBLE;
    assign out_halt  = out_valid && head[DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            halt_lock <= 1'b0;
        end else if (flush) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            halt_lock <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= advance(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= advance(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (push && in_halt) begin
                halt_lock <= 1'b1;
            end
        end
    end

    // Payload storage is deliberately not reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_halt, in_data};
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid && !out_ready && !flush),
        .clear (1'b0),
        .value (stall_cnt)
    );

    assert property (@(posedge clk) disable iff (rst) count <= FULL);
    assert property (@(posedge clk) disable iff (rst) !(push && (count == FULL)));
    assert property (@(posedge clk) disable iff (rst) !(pop && (count == '0)));

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench: three buffers (DEPTH 2, 1, 8; CNT_W 4) checked every cycle
// against a queue scoreboard plus directed expectations.
module tb_pipe_stage_buf;

    localparam int          NDUT           = 3;
    localparam int          DEPTHS [NDUT]  = '{2, 1, 8};
    localparam logic [7:0]  BUBBLE         = 8'hEE;
    localparam int          STALL_MAX      = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid  [NDUT];
    logic       in_halt   [NDUT];
    logic       out_ready [NDUT];
    logic       flush     [NDUT];
    logic [7:0] in_data   [NDUT];
    logic       in_ready  [NDUT];
    logic       out_valid [NDUT];
    logic       out_halt  [NDUT];
    logic [7:0] out_data  [NDUT];
    logic [3:0] stall_cnt [NDUT];
    logic [31:0] count_obs [NDUT];

    logic [8:0] sb [NDUT][$];
    logic       lock_m  [NDUT];
    int         stall_m [NDUT];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int D = DEPTHS[g];
        logic [$clog2(D):0] count;

        pipe_stage_buf #(
            .DATA_W (8),
            .DEPTH  (D),
            .BUBBLE (BUBBLE),
            .CNT_W  (4)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .in_halt   (in_halt[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .out_halt  (out_halt[g]),
            .count     (count),
            .stall_cnt (stall_cnt[g])
        );

        assign count_obs[g] = 32'(count);
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [7:0] d,
                         input logic h, input logic r, input logic f);
        in_valid[i]  = v;
        in_data[i]   = d;
        in_halt[i]   = h;
        out_ready[i] = r;
        flush[i]     = f;
    endtask

    task automatic idleAll();
        for (int i = 0; i < NDUT; i++) drive(i, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resetModel();
        for (int i = 0; i < NDUT; i++) begin
            sb[i].delete();
            lock_m[i]  = 1'b0;
            stall_m[i] = 0;
        end
    endtask

    task automatic checkOutput(input int i);
        logic       v;
        logic [8:0] head;
        v    = (sb[i].size() != 0);
        head = v ? sb[i][0] : 9'h000;
        checkVal($sformatf("d%0d out_valid", i), 32'(out_valid[i]), 32'(v));
        checkVal($sformatf("d%0d out_data", i), 32'(out_data[i]), 32'(v ? head[7:0] : BUBBLE));
        checkVal($sformatf("d%0d out_halt", i), 32'(out_halt[i]), 32'(v && head[8]));
        checkVal($sformatf("d%0d in_ready", i), 32'(in_ready[i]),
                 32'((sb[i].size() < DEPTHS[i]) && !lock_m[i]));
        checkVal($sformatf("d%0d count", i), count_obs[i], 32'(sb[i].size()));
        checkVal($sformatf("d%0d stall_cnt", i), 32'(stall_cnt[i]), 32'(stall_m[i]));
    endtask

    // One clock: the model consumes the inputs seen at the edge, then all outputs are compared.
    task automatic applyStimulus();
        logic push;
        logic pop;
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) begin
            if (flush[i]) begin
                sb[i].delete();
                lock_m[i] = 1'b0;
            end else begin
                push = in_valid[i] && (sb[i].size() < DEPTHS[i]) && !lock_m[i];
                pop  = (sb[i].size() != 0) && out_ready[i];
                if ((sb[i].size() != 0) && !out_ready[i] && (stall_m[i] < STALL_MAX)) stall_m[i]++;
                if (pop) void'(sb[i].pop_front());
                if (push) begin
                    sb[i].push_back({in_halt[i], in_data[i]});
                    if (in_halt[i]) lock_m[i] = 1'b1;
                end
            end
        end
        #1;
        for (int i = 0; i < NDUT; i++) checkOutput(i);
    endtask

    initial begin
        rst = 1'b1;
        idleAll();
        resetModel();
        #1;
        for (int i = 0; i < NDUT; i++) checkOutput(i);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        applyStimulus();
        checkVal("reset in_ready", 32'(in_ready[0]), 32'd1);
        checkVal("reset out_data", 32'(out_data[0]), 32'hEE);
        checkVal("reset count", count_obs[0], 32'd0);

        // Fill DEPTH=2 with downstream stalled, then drain in order.
        drive(0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        drive(0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        checkVal("full count", count_obs[0], 32'd2);
        checkVal("full in_ready", 32'(in_ready[0]), 32'd0);
        checkVal("full head", 32'(out_data[0]), 32'h11);
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (5) applyStimulus();
        // The cycle that pushed 0x22 already had 0x11 waiting, so it stalled too.
        checkVal("stall after hold", 32'(stall_cnt[0]), 32'd6);
        drive(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus();
        checkVal("second pop head", 32'(out_data[0]), 32'h22);
        applyStimulus();
        checkVal("drained count", count_obs[0], 32'd0);

        // Halt lock-out.
        drive(0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        drive(0, 1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
        applyStimulus();
        checkVal("halt in_ready", 32'(in_ready[0]), 32'd0);
        drive(0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        drive(0, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
        applyStimulus();
        checkVal("halt head data", 32'(out_data[0]), 32'h44);
        checkVal("halt head flag", 32'(out_halt[0]), 32'd1);
        applyStimulus();
        checkVal("halt drained count", count_obs[0], 32'd0);
        checkVal("halt still locked", 32'(in_ready[0]), 32'd0);
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        checkVal("unlock in_ready", 32'(in_ready[0]), 32'd1);

        // Flush while full, with a push and pop attempted in the same cycle.
        drive(0, 1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        drive(0, 1'b1, 8'h72, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        drive(0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
        applyStimulus();
        checkVal("flush count", count_obs[0], 32'd0);
        checkVal("flush out_valid", 32'(out_valid[0]), 32'd0);
        drive(0, 1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        drive(0, 1'b1, 8'h79, 1'b0, 1'b1, 1'b1);
        applyStimulus();
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) applyStimulus();

        // Streaming through all three depths at once.
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < NDUT; i++) drive(i, 1'b1, 8'(k), 1'b0, 1'b1, 1'b0);
            applyStimulus();
        end
        checkVal("stream d8 head", 32'(out_data[2]), 32'h0F);
        for (int i = 0; i < NDUT; i++) drive(i, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus();

        // Asynchronous reset between edges.
        for (int i = 0; i < NDUT; i++) drive(i, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        for (int i = 0; i < NDUT; i++) drive(i, 1'b1, 8'h82, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        #2 rst = 1'b1;
        resetModel();
        #1;
        for (int i = 0; i < NDUT; i++) checkOutput(i);
        checkVal("async out_valid", 32'(out_valid[2]), 32'd0);
        idleAll();
        #1 rst = 1'b0;

        // Stall counter saturation.
        drive(0, 1'b1, 8'h90, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (20) applyStimulus();
        checkVal("stall saturated", 32'(stall_cnt[0]), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
